// File: rtl/keypad_div_ctrl.sv
// Keypad entry and launch sequencer for the 16-bit divider datapath.
// Scans a 4x4 keypad plus an '=' button, builds decimal dividend/divisor
// operands, launches the divider and holds its result for display.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ENTER_A | digits accumulate into dividend
//   ENTER_B | digits accumulate into divisor, '=' launches or flags /0
//   RUN     | divider busy, waiting for div_done
//   SHOW    | quotient/remainder held for display
module keypad_div_ctrl #(
    parameter int W        = 16,
    parameter int DEBOUNCE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   rowk,
    input  logic [3:0]   columnk,
    input  logic         equal,
    input  logic         div_done,
    input  logic [W-1:0] div_quotient,
    input  logic [W-1:0] div_remainder,
    output logic [W-1:0] dividend,
    output logic [W-1:0] divisor,
    output logic         div_start,
    output logic         div_abort,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         div_err,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        RUN     = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam int            CW    = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DB    = CW'(DEBOUNCE);
    localparam logic [1:0]    K_REL = 2'd0;
    localparam logic [1:0]    K_KEY = 2'd1;
    localparam logic [1:0]    K_BAD = 2'd2;
    localparam logic [W+3:0]  LIMIT = {4'b0, {W{1'b1}}};

    // bit index of a one-hot nibble (only meaningful when one-hot)
    function automatic logic [1:0] enc4(input logic [3:0] v);
        case (v)
            4'b0001: enc4 = 2'd0;
            4'b0010: enc4 = 2'd1;
            4'b0100: enc4 = 2'd2;
            default: enc4 = 2'd3;
        endcase
    endfunction

    logic [3:0]    row_s1, row_s2, col_s1, col_s2;
    logic          eq_s1, eq_s2;

    logic [1:0]    k_kind, k_r, k_c;
    logic [5:0]    k_samp, k_last;
    logic [CW-1:0] k_cnt, k_cnt_n, e_cnt, e_cnt_n;
    logic          k_armed, k_fire, k_rearm;
    logic          e_last, e_armed, e_fire, e_rearm;
    logic          is_digit, is_div, is_clr;
    logic [3:0]    digit;

    logic          ev_digit, ev_div, ev_clr, ev_eq;
    logic [3:0]    ev_val;

    state_t        state_q, state_n;
    logic [W-1:0]  dividend_n, divisor_n, quotient_n, remainder_n;
    logic          err_n;
    logic [W+3:0]  acc_a, acc_b;

    // two-flop synchronizers for the asynchronous keypad and button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1 <= '0;
            row_s2 <= '0;
            col_s1 <= '0;
            col_s2 <= '0;
            eq_s1  <= 1'b0;
            eq_s2  <= 1'b0;
        end else begin
            row_s1 <= rowk;
            row_s2 <= row_s1;
            col_s1 <= columnk;
            col_s2 <= col_s1;
            eq_s1  <= equal;
            eq_s2  <= eq_s1;
        end
    end

    // classify the synced sample and count how long it has been stable;
    // a malformed pattern neither fires nor counts as a release
    always_comb begin
        k_r = enc4(row_s2);
        k_c = enc4(col_s2);
        if (row_s2 == 4'b0 && col_s2 == 4'b0) begin
            k_kind = K_REL;
        end else if ($onehot(row_s2) && $onehot(col_s2)) begin
            k_kind = K_KEY;
        end else begin
            k_kind = K_BAD;
        end
        k_samp  = (k_kind == K_KEY) ? {k_kind, k_r, k_c} : {k_kind, 4'b0};
        k_cnt_n = (k_samp == k_last) ? ((k_cnt == DB) ? k_cnt : k_cnt + CW'(1)) : CW'(1);
        k_fire  = k_armed && (k_kind == K_KEY) && (k_cnt_n == DB);
        k_rearm = (k_kind == K_REL) && (k_cnt_n == DB);

        // a coincident key event wins; '=' stays armed and fires a cycle later
        e_cnt_n = (eq_s2 == e_last) ? ((e_cnt == DB) ? e_cnt : e_cnt + CW'(1)) : CW'(1);
        e_fire  = e_armed && eq_s2 && (e_cnt_n == DB) && !k_fire;
        e_rearm = !eq_s2 && (e_cnt_n == DB);

        is_digit = (k_r != 2'd3 && k_c != 2'd3) || (k_r == 2'd3 && k_c == 2'd1);
        is_div   = (k_r == 2'd3) && (k_c == 2'd0);
        is_clr   = (k_r == 2'd3) && (k_c == 2'd2);
        digit    = (k_r == 2'd3) ? 4'd0 : ({2'b0, k_r} * 4'd3 + {2'b0, k_c} + 4'd1);
    end

    // debouncer state and registered one-cycle key/'=' events
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_last   <= {K_REL, 4'b0};
            k_cnt    <= '0;
            k_armed  <= 1'b1;
            e_last   <= 1'b0;
            e_cnt    <= '0;
            e_armed  <= 1'b1;
            ev_digit <= 1'b0;
            ev_val   <= '0;
            ev_div   <= 1'b0;
            ev_clr   <= 1'b0;
            ev_eq    <= 1'b0;
        end else begin
            k_last <= k_samp;
            k_cnt  <= k_cnt_n;
            if (k_fire) begin
                k_armed <= 1'b0;
            end else if (k_rearm) begin
                k_armed <= 1'b1;
            end
            e_last <= eq_s2;
            e_cnt  <= e_cnt_n;
            if (e_fire) begin
                e_armed <= 1'b0;
            end else if (e_rearm) begin
                e_armed <= 1'b1;
            end
            ev_digit <= k_fire && is_digit;
            ev_val   <= digit;
            ev_div   <= k_fire && is_div;
            ev_clr   <= k_fire && is_clr;
            ev_eq    <= e_fire;
        end
    end

    // next-state, operand/result updates and launch/abort strobes
    always_comb begin
        state_n     = state_q;
        dividend_n  = dividend;
        divisor_n   = divisor;
        quotient_n  = quotient;
        remainder_n = remainder;
        err_n       = div_err;
        div_start   = 1'b0;
        div_abort   = 1'b0;

        // an overflowing digit is dropped rather than wrapping the field
        acc_a = {4'b0, dividend} * (W+4)'(10) + {{W{1'b0}}, ev_val};
        acc_b = {4'b0, divisor}  * (W+4)'(10) + {{W{1'b0}}, ev_val};

        if (ev_clr) begin
            state_n     = ENTER_A;
            dividend_n  = '0;
            divisor_n   = '0;
            quotient_n  = '0;
            remainder_n = '0;
            err_n       = 1'b0;
            div_abort   = (state_q == RUN);
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (ev_digit) begin
                        if (acc_a <= LIMIT) dividend_n = acc_a[W-1:0];
                    end else if (ev_div) begin
                        state_n   = ENTER_B;
                        divisor_n = '0;
                    end
                end
                ENTER_B: begin
                    if (ev_digit) begin
                        if (acc_b <= LIMIT) divisor_n = acc_b[W-1:0];
                    end else if (ev_eq) begin
                        if (divisor == '0) begin
                            state_n     = SHOW;
                            err_n       = 1'b1;
                            quotient_n  = '1;
                            remainder_n = dividend;
                        end else begin
                            state_n   = RUN;
                            div_start = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (div_done) begin
                        state_n     = SHOW;
                        quotient_n  = div_quotient;
                        remainder_n = div_remainder;
                    end
                end
                SHOW: begin
                    if (ev_digit) begin
                        state_n    = ENTER_A;
                        dividend_n = W'(ev_val);
                        divisor_n  = '0;
                        err_n      = 1'b0;
                    end else if (ev_div) begin
                        state_n   = ENTER_B;
                        divisor_n = '0;
                        err_n     = 1'b0;
                    end
                end
                default: state_n = ENTER_A;
            endcase
        end
    end

    // controller state and architectural registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ENTER_A;
            dividend  <= '0;
            divisor   <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_err   <= 1'b0;
        end else begin
            state_q   <= state_n;
            dividend  <= dividend_n;
            divisor   <= divisor_n;
            quotient  <= quotient_n;
            remainder <= remainder_n;
            div_err   <= err_n;
        end
    end

    assign busy  = (state_q == RUN);
    assign state = state_q;

endmodule

// File: tb/tb_keypad_div_ctrl.sv
// Bench for keypad_div_ctrl: vector table, directed corner sequences and a
// randomized press stream checked against a press-level calculator model.
module tb_keypad_div_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rowk, columnk;
    logic         equal, div_done;
    logic [W-1:0] div_quotient, div_remainder;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    logic         div_start, div_abort, busy, div_err;
    logic [1:0]   state;

    keypad_div_ctrl #(.W(W), .DEBOUNCE(2)) dut (
        .clk(clk), .rst(rst), .rowk(rowk), .columnk(columnk), .equal(equal),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .dividend(dividend), .divisor(divisor), .div_start(div_start), .div_abort(div_abort),
        .quotient(quotient), .remainder(remainder), .busy(busy), .div_err(div_err),
        .state(state)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // divider model: answers div_latency cycles after div_start; never cancels,
    // so an aborted run still produces a late div_done
    int           div_lat = 16;
    bit           pend = 0;
    int           dcnt = 0;
    logic [W-1:0] cap_a, cap_b;
    initial begin
        div_done = 1'b0; div_quotient = '0; div_remainder = '0;
        forever begin
            @(negedge clk);
            div_done = 1'b0;
            if (pend) begin
                dcnt--;
                if (dcnt <= 0) begin
                    pend          = 0;
                    div_done      = 1'b1;
                    div_quotient  = (cap_b == 0) ? '1 : cap_a / cap_b;
                    div_remainder = (cap_b == 0) ? cap_a : cap_a % cap_b;
                end
            end
            if (div_start === 1'b1) begin
                pend = 1; dcnt = div_lat; cap_a = dividend; cap_b = divisor;
            end
        end
    end

    // strobe monitor
    int start_cnt = 0, abort_cnt = 0, busy_cnt = 0, overlap_cnt = 0, abort_dbl = 0;
    bit abort_prev = 0;
    initial forever begin
        @(negedge clk);
        if (div_start === 1'b1 && div_abort === 1'b1) overlap_cnt++;
        if (div_start === 1'b1) start_cnt++;
        if (div_abort === 1'b1) abort_cnt++;
        if (div_abort === 1'b1 && abort_prev) abort_dbl++;
        if (busy === 1'b1) busy_cnt++;
        abort_prev = (div_abort === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int r, input int c);
        rowk = 4'(1 << r); columnk = 4'(1 << c);
        idle(6);
        rowk = 4'b0; columnk = 4'b0;
        idle(6);
    endtask

    task automatic press_eq();
        equal = 1'b1; idle(6); equal = 1'b0; idle(6);
    endtask

    task automatic press_digit(input int d);
        if (d == 0) press(3, 1);
        else press((d - 1) / 3, (d - 1) % 3);
    endtask

    task automatic press_div(); press(3, 0); endtask
    task automatic press_clr(); press(3, 2); endtask

    task automatic wait_state(input int exp, input int maxc, input string name);
        int k = 0;
        while (state !== 2'(exp) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(state), exp);
    endtask

    // press-level calculator model
    int m_st, m_a, m_b, m_q, m_r, m_err, m_starts;

    task automatic m_clr();
        m_st = 0; m_a = 0; m_b = 0; m_q = 0; m_r = 0; m_err = 0;
    endtask

    task automatic m_digit(input int d);
        if (m_st == 0 && m_a * 10 + d <= 65535) m_a = m_a * 10 + d;
        else if (m_st == 1 && m_b * 10 + d <= 65535) m_b = m_b * 10 + d;
        else if (m_st == 3) begin m_st = 0; m_a = d; m_b = 0; m_err = 0; end
    endtask

    task automatic m_div();
        if (m_st == 0 || m_st == 3) begin m_st = 1; m_b = 0; m_err = 0; end
    endtask

    task automatic m_eq();
        if (m_st == 1) begin
            if (m_b == 0) begin m_st = 3; m_err = 1; m_q = 65535; m_r = m_a; end
            else begin m_st = 2; m_starts++; end
        end
    endtask

    task automatic m_done();
        if (m_st == 2) begin m_q = m_a / m_b; m_r = m_a % m_b; m_st = 3; end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " dividend"},  32'(dividend),  m_a);
        chk({tag, " divisor"},   32'(divisor),   m_b);
        chk({tag, " state"},     32'(state),     m_st);
        chk({tag, " quotient"},  32'(quotient),  m_q);
        chk({tag, " remainder"}, 32'(remainder), m_r);
        chk({tag, " div_err"},   32'(div_err),   m_err);
    endtask

    typedef struct {
        int kind;   // 0 = keypad press at (r,c), 1 = '=' press
        int r;
        int c;
        int exp_a;
        int exp_b;
        int exp_st;
        int exp_err;
    } vec_t;
    vec_t vecs [13];

    task automatic apply_vec(input int i);
        if (vecs[i].kind == 0) press(vecs[i].r, vecs[i].c);
        else press_eq();
        chk($sformatf("vec%0d dividend", i), 32'(dividend), vecs[i].exp_a);
        chk($sformatf("vec%0d divisor", i),  32'(divisor),  vecs[i].exp_b);
        chk($sformatf("vec%0d state", i),    32'(state),    vecs[i].exp_st);
        chk($sformatf("vec%0d div_err", i),  32'(div_err),  vecs[i].exp_err);
    endtask

    initial begin
        int base_start, base_abort, base_busy;

        vecs[0]  = '{0, 0, 2,   53, 0, 0, 0};   // 3
        vecs[1]  = '{0, 3, 0,   53, 0, 1, 0};   // DIV
        vecs[2]  = '{0, 2, 0,   53, 7, 1, 0};   // 7
        vecs[3]  = '{1, 0, 0,   53, 7, 2, 0};   // = -> RUN
        vecs[4]  = '{0, 3, 2,    0, 0, 0, 0};   // CLR
        vecs[5]  = '{0, 1, 2,    6, 0, 0, 0};   // 6
        vecs[6]  = '{0, 1, 1,   65, 0, 0, 0};   // 5
        vecs[7]  = '{0, 1, 1,  655, 0, 0, 0};   // 5
        vecs[8]  = '{0, 0, 2, 6553, 0, 0, 0};   // 3
        vecs[9]  = '{0, 1, 2, 6553, 0, 0, 0};   // 6 dropped (65536)
        vecs[10] = '{0, 3, 0, 6553, 0, 1, 0};   // DIV
        vecs[11] = '{0, 3, 1, 6553, 0, 1, 0};   // 0
        vecs[12] = '{1, 0, 0, 6553, 0, 3, 1};   // = with divisor 0

        // reset state and quiet release
        rst = 1'b0; rowk = 4'b0; columnk = 4'b0; equal = 1'b0;
        idle(2);
        chk("reset dividend",  32'(dividend),  0);
        chk("reset divisor",   32'(divisor),   0);
        chk("reset quotient",  32'(quotient),  0);
        chk("reset remainder", 32'(remainder), 0);
        chk("reset div_start", 32'(div_start), 0);
        chk("reset div_abort", 32'(div_abort), 0);
        chk("reset busy",      32'(busy),      0);
        chk("reset div_err",   32'(div_err),   0);
        chk("reset state",     32'(state),     0);
        rst = 1'b1;
        idle(10);
        chk("post-reset state",    32'(state),    0);
        chk("post-reset dividend", 32'(dividend), 0);
        chk("post-reset starts",   start_cnt,     0);

        // key 5: register update lands exactly four edges after the first sampling edge
        rowk = 4'b0010; columnk = 4'b0010;
        idle(4);
        chk("key latency not early", 32'(dividend), 0);
        idle(1);
        chk("key latency lands", 32'(dividend), 5);
        idle(1);
        rowk = 4'b0; columnk = 4'b0;
        idle(6);

        // 53 / 7 with a 16-cycle divider
        div_lat = 16;
        for (int i = 0; i <= 2; i++) apply_vec(i);
        base_busy = busy_cnt;
        apply_vec(3);
        wait_state(3, 40, "53/7 completes");
        chk("53/7 busy cycles", busy_cnt - base_busy, 16);
        chk("53/7 quotient",    32'(quotient),  7);
        chk("53/7 remainder",   32'(remainder), 4);
        chk("53/7 one start",   start_cnt,      1);

        // overflow drop and divide by zero
        for (int i = 4; i <= 12; i++) apply_vec(i);
        chk("div0 quotient",  32'(quotient),  32'h0000_FFFF);
        chk("div0 remainder", 32'(remainder), 6553);
        chk("div0 no start",  start_cnt,      1);

        // new digit from SHOW (error result)
        press_digit(8);
        chk("show8 state",     32'(state),     0);
        chk("show8 dividend",  32'(dividend),  8);
        chk("show8 divisor",   32'(divisor),   0);
        chk("show8 quotient",  32'(quotient),  32'h0000_FFFF);
        chk("show8 remainder", 32'(remainder), 6553);
        chk("show8 div_err",   32'(div_err),   0);

        // new digit from SHOW (real result)
        press_clr(); press_digit(9); press_div(); press_digit(2);
        div_lat = 16; press_eq();
        wait_state(3, 40, "9/2 completes");
        chk("9/2 quotient", 32'(quotient), 4);
        press_digit(8);
        chk("show8b state",     32'(state),     0);
        chk("show8b dividend",  32'(dividend),  8);
        chk("show8b quotient",  32'(quotient),  4);
        chk("show8b remainder", 32'(remainder), 1);

        // held key, malformed patterns and a one-cycle glitch give a single digit
        press_clr();
        rowk = 4'b0001; columnk = 4'b0010;
        idle(20);
        for (int i = 0; i < 3; i++) begin
            rowk = 4'b1100; columnk = 4'b0010; idle(2);
            rowk = 4'b0001; columnk = 4'b0010; idle(3);
        end
        rowk = 4'b0; columnk = 4'b0; idle(10);
        rowk = 4'b0100; columnk = 4'b0100; idle(1);
        rowk = 4'b0; columnk = 4'b0; idle(10);
        chk("held/glitch dividend", 32'(dividend), 2);
        chk("held/glitch state",    32'(state),    0);

        // CLR while busy, done arriving after the abort
        press_clr(); press_digit(9); press_div(); press_digit(2);
        base_abort = abort_cnt;
        div_lat = 16; press_eq();
        chk("abort run state", 32'(state), 2);
        press_clr();
        chk("abort single pulse", abort_cnt - base_abort, 1);
        chk("abort state",     32'(state),     0);
        chk("abort dividend",  32'(dividend),  0);
        chk("abort divisor",   32'(divisor),   0);
        chk("abort quotient",  32'(quotient),  0);
        chk("abort remainder", 32'(remainder), 0);
        idle(10);
        chk("late done state",    32'(state),    0);
        chk("late done quotient", 32'(quotient), 0);

        // CLR event and div_done in the same cycle: done discarded
        press_digit(9); press_div(); press_digit(2);
        base_abort = abort_cnt;
        div_lat = 12; press_eq();
        press_clr();
        chk("clr+done abort",     abort_cnt - base_abort, 1);
        chk("clr+done state",     32'(state),     0);
        chk("clr+done quotient",  32'(quotient),  0);
        chk("clr+done remainder", 32'(remainder), 0);
        idle(10);

        // asynchronous reset in RUN: immediate ENTER_A, no abort
        press_digit(9); press_div(); press_digit(2);
        base_abort = abort_cnt;
        div_lat = 16; press_eq();
        #2 rst = 1'b0;
        #1;
        chk("rst-in-run state", 32'(state), 0);
        chk("rst-in-run busy",  32'(busy),  0);
        idle(2);
        rst = 1'b1;
        idle(25);
        chk("rst-in-run no abort", abort_cnt - base_abort, 0);
        chk("rst-in-run quotient", 32'(quotient), 0);

        // randomized press stream against the calculator model
        m_clr(); m_starts = 0;
        base_start = start_cnt;
        for (int it = 0; it < 250; it++) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel < 12) begin
                int d;
                d = $urandom_range(0, 9);
                press_digit(d); m_digit(d);
            end else if (sel < 15) begin
                press_div(); m_div();
            end else if (sel < 19) begin
                div_lat = $urandom_range(1, 20);
                press_eq(); m_eq();
            end else begin
                press_clr(); m_clr();
            end
            if (m_st == 2) begin
                if ($urandom_range(0, 4) == 0) begin
                    press_clr(); m_clr();
                    idle(20);
                end else begin
                    wait_state(3, 60, "random run completes");
                    m_done();
                end
            end
            chk_model($sformatf("rand%0d", it));
        end
        chk("random start count", start_cnt - base_start, m_starts);

        chk("start/abort overlap", overlap_cnt, 0);
        chk("abort pulse width",   abort_dbl,   0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
